// File: rtl/video_timing_pkg.sv
// Default raster geometry and shared types for the video timing generator.
package video_timing_pkg;

  localparam int DEF_H_TOTAL        = 310;
  localparam int DEF_V_TOTAL        = 263;
  localparam int DEF_H_SYNC_START   = 287;
  localparam int DEF_H_SYNC_LEN     = 23;
  localparam int DEF_V_SYNC_LEN     = 3;
  localparam int DEF_H_ACTIVE_START = 9;
  localparam int DEF_V_ACTIVE_START = 26;
  localparam int DEF_H_ACTIVE       = 256;
  localparam int DEF_V_ACTIVE       = 192;
  localparam int DEF_SCALE_LOG2     = 2;
  localparam int DEF_SHIFT_W        = 4;
  localparam int DEF_POS_W          = 10;

  // Raster position at the default counter width.
  typedef logic [DEF_POS_W-1:0] pos_t;

endpackage

// File: rtl/wrap_counter.sv
// Modulus counter with enable, async reset and terminal-count carry.
// Exposes the next-state value so the owner can register outputs
// that line up with the counter on the same edge.
module wrap_counter #(
  parameter int MOD = 2,
  parameter int W   = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count_next,
  output logic         carry
);

  logic [W-1:0] count;
  logic         at_term;

  assign at_term = (count == W'(MOD - 1));
  assign carry   = en && at_term;

  // Next count: hold when disabled, wrap to zero after MOD-1.
  always_comb begin
    count_next = count;
    if (en) begin
      count_next = at_term ? '0 : count + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: sync, blanking, signed pixel position,
// scaled cell position and line/frame strobes. Every output is a
// register loaded from the counters' next state, so outputs always
// describe the position the counters hold after the same edge.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_TOTAL        = DEF_H_TOTAL,
  parameter int V_TOTAL        = DEF_V_TOTAL,
  parameter int H_SYNC_START   = DEF_H_SYNC_START,
  parameter int H_SYNC_LEN     = DEF_H_SYNC_LEN,
  parameter int V_SYNC_LEN     = DEF_V_SYNC_LEN,
  parameter int H_ACTIVE_START = DEF_H_ACTIVE_START,
  parameter int V_ACTIVE_START = DEF_V_ACTIVE_START,
  parameter int H_ACTIVE       = DEF_H_ACTIVE,
  parameter int V_ACTIVE       = DEF_V_ACTIVE,
  parameter int SCALE_LOG2     = DEF_SCALE_LOG2,
  parameter int SHIFT_W        = DEF_SHIFT_W,
  parameter int POS_W          = DEF_POS_W,
  parameter bit H_SYNC_POL     = 1'b1,
  parameter bit V_SYNC_POL     = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [SHIFT_W-1:0]          hShift,
  input  logic [SHIFT_W-1:0]          vShift,
  output logic                        hSync,
  output logic                        vSync,
  output logic                        isActive,
  output logic [POS_W-1:0]            xPos,
  output logic [POS_W-1:0]            yPos,
  output logic [POS_W-SCALE_LOG2-1:0] xCell,
  output logic [POS_W-SCALE_LOG2-1:0] yCell,
  output logic                        lineStart,
  output logic                        frameStart
);

  // Geometry sanity: refuse to elaborate an impossible raster.
  if (H_SYNC_START + H_SYNC_LEN > H_TOTAL) begin : g_bad_hsync
    $error("video_timing_gen: hsync window extends past H_TOTAL");
  end
  if (V_SYNC_LEN >= V_TOTAL) begin : g_bad_vsync
    $error("video_timing_gen: V_SYNC_LEN must be below V_TOTAL");
  end
  if ((H_ACTIVE_START + H_ACTIVE > H_TOTAL) ||
      (V_ACTIVE_START + V_ACTIVE > V_TOTAL)) begin : g_bad_active
    $error("video_timing_gen: active region exceeds raster total");
  end
  if ((H_TOTAL >= (1 << (POS_W - 1))) ||
      (V_TOTAL >= (1 << (POS_W - 1)))) begin : g_bad_width
    $error("video_timing_gen: POS_W too narrow for signed positions");
  end

  logic [POS_W-1:0]            col_next;
  logic [POS_W-1:0]            line_next;
  logic                        col_carry;
  logic                        line_carry;

  logic [SHIFT_W-1:0]          hshift_q;
  logic [SHIFT_W-1:0]          vshift_q;
  logic [SHIFT_W-1:0]          hshift_next;
  logic [SHIFT_W-1:0]          vshift_next;

  logic [POS_W-1:0]            x_next;
  logic [POS_W-1:0]            y_next;
  logic                        act_next;
  logic                        hs_next;
  logic                        vs_next;
  logic [POS_W-SCALE_LOG2-1:0] xc_next;
  logic [POS_W-SCALE_LOG2-1:0] yc_next;

  wrap_counter #(
    .MOD (H_TOTAL),
    .W   (POS_W)
  ) u_col (
    .clk        (clk),
    .reset      (reset),
    .en         (enable),
    .count_next (col_next),
    .carry      (col_carry)
  );

  // The line counter steps on the column carry, so its carry marks
  // the single enabled advance into (0,0).
  wrap_counter #(
    .MOD (V_TOTAL),
    .W   (POS_W)
  ) u_line (
    .clk        (clk),
    .reset      (reset),
    .en         (col_carry),
    .count_next (line_next),
    .carry      (line_carry)
  );

  // Border shifts are sampled only on entry to a new frame.
  always_comb begin
    hshift_next = hshift_q;
    vshift_next = vshift_q;
    if (line_carry) begin
      hshift_next = hShift;
      vshift_next = vShift;
    end
  end

  // Latched border shift registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hshift_q <= '0;
      vshift_q <= '0;
    end else begin
      hshift_q <= hshift_next;
      vshift_q <= vshift_next;
    end
  end

  // Output values for the position the counters are about to hold.
  // Active test: sign bit clear, then an unsigned upper-bound compare.
  always_comb begin
    x_next   = col_next  - POS_W'(H_ACTIVE_START) - POS_W'(hshift_next);
    y_next   = line_next - POS_W'(V_ACTIVE_START) - POS_W'(vshift_next);
    act_next = !x_next[POS_W-1] && (x_next < POS_W'(H_ACTIVE)) &&
               !y_next[POS_W-1] && (y_next < POS_W'(V_ACTIVE));
    hs_next  = !H_SYNC_POL;
    if ((col_next >= POS_W'(H_SYNC_START)) &&
        (col_next <  POS_W'(H_SYNC_START + H_SYNC_LEN))) begin
      hs_next = H_SYNC_POL;
    end
    vs_next  = !V_SYNC_POL;
    if (line_next < POS_W'(V_SYNC_LEN)) begin
      vs_next = V_SYNC_POL;
    end
    xc_next  = '0;
    yc_next  = '0;
    if (act_next) begin
      xc_next = x_next[POS_W-1:SCALE_LOG2];
      yc_next = y_next[POS_W-1:SCALE_LOG2];
    end
  end

  // Registered outputs; strobes come straight from the counter carries,
  // which already include the enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hSync      <= !H_SYNC_POL;
      vSync      <= V_SYNC_POL;
      isActive   <= 1'b0;
      xPos       <= '0 - POS_W'(H_ACTIVE_START);
      yPos       <= '0 - POS_W'(V_ACTIVE_START);
      xCell      <= '0;
      yCell      <= '0;
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
    end else begin
      hSync      <= hs_next;
      vSync      <= vs_next;
      isActive   <= act_next;
      xPos       <= x_next;
      yPos       <= y_next;
      xCell      <= xc_next;
      yCell      <= yc_next;
      lineStart  <= col_carry;
      frameStart <= line_carry;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: three instances (default geometry, a small
// raster, and a tiny raster with inverted syncs) checked every cycle
// against a position-count reference model.
module tb_video_timing_gen;

  localparam int N = 3;

  localparam int S_HT = 40, S_VT = 30, S_HSS = 33, S_HSL = 5, S_VSL = 3;
  localparam int S_HAS = 3, S_VAS = 4, S_HA = 24, S_VA = 16, S_SC = 2, S_PW = 8;

  localparam int I_HT = 20, I_VT = 10, I_HSS = 15, I_HSL = 3, I_VSL = 2;
  localparam int I_HAS = 2, I_VAS = 2, I_HA = 12, I_VA = 6, I_SC = 1, I_PW = 6;

  typedef struct {
    int ht, vt, hss, hsl, vsl, has, vas, ha, va, sc, pw;
    bit hp, vp;
  } geom_t;

  typedef struct packed {
    logic               hs;
    logic               vs;
    logic               act;
    logic signed [31:0] x;
    logic signed [31:0] y;
    logic signed [31:0] xc;
    logic signed [31:0] yc;
    logic               ls;
    logic               fs;
  } out_t;

  logic       clk = 1'b0;
  logic       rst [N];
  logic       en  [N];
  logic [3:0] hsh [N];
  logic [3:0] vsh [N];

  geom_t g   [N];
  int    n   [N];
  int    hl  [N];
  int    vl  [N];
  bit    adv [N];
  out_t  obs [N];

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  logic       d_hs, d_vs, d_act, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  logic [7:0] d_xc, d_yc;

  logic       s_hs, s_vs, s_act, s_ls, s_fs;
  logic [7:0] s_x, s_y;
  logic [5:0] s_xc, s_yc;

  logic       i_hs, i_vs, i_act, i_ls, i_fs;
  logic [5:0] i_x, i_y;
  logic [4:0] i_xc, i_yc;

  video_timing_gen u_def (
    .clk(clk), .reset(rst[0]), .enable(en[0]), .hShift(hsh[0]), .vShift(vsh[0]),
    .hSync(d_hs), .vSync(d_vs), .isActive(d_act), .xPos(d_x), .yPos(d_y),
    .xCell(d_xc), .yCell(d_yc), .lineStart(d_ls), .frameStart(d_fs)
  );

  video_timing_gen #(
    .H_TOTAL(S_HT), .V_TOTAL(S_VT), .H_SYNC_START(S_HSS), .H_SYNC_LEN(S_HSL),
    .V_SYNC_LEN(S_VSL), .H_ACTIVE_START(S_HAS), .V_ACTIVE_START(S_VAS),
    .H_ACTIVE(S_HA), .V_ACTIVE(S_VA), .SCALE_LOG2(S_SC), .SHIFT_W(4),
    .POS_W(S_PW), .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
  ) u_dut (
    .clk(clk), .reset(rst[1]), .enable(en[1]), .hShift(hsh[1]), .vShift(vsh[1]),
    .hSync(s_hs), .vSync(s_vs), .isActive(s_act), .xPos(s_x), .yPos(s_y),
    .xCell(s_xc), .yCell(s_yc), .lineStart(s_ls), .frameStart(s_fs)
  );

  video_timing_gen #(
    .H_TOTAL(I_HT), .V_TOTAL(I_VT), .H_SYNC_START(I_HSS), .H_SYNC_LEN(I_HSL),
    .V_SYNC_LEN(I_VSL), .H_ACTIVE_START(I_HAS), .V_ACTIVE_START(I_VAS),
    .H_ACTIVE(I_HA), .V_ACTIVE(I_VA), .SCALE_LOG2(I_SC), .SHIFT_W(4),
    .POS_W(I_PW), .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0)
  ) u_inv (
    .clk(clk), .reset(rst[2]), .enable(en[2]), .hShift(hsh[2]), .vShift(vsh[2]),
    .hSync(i_hs), .vSync(i_vs), .isActive(i_act), .xPos(i_x), .yPos(i_y),
    .xCell(i_xc), .yCell(i_yc), .lineStart(i_ls), .frameStart(i_fs)
  );

  assign obs[0] = {d_hs, d_vs, d_act, 32'($signed(d_x)), 32'($signed(d_y)),
                   32'(d_xc), 32'(d_yc), d_ls, d_fs};
  assign obs[1] = {s_hs, s_vs, s_act, 32'($signed(s_x)), 32'($signed(s_y)),
                   32'(s_xc), 32'(s_yc), s_ls, s_fs};
  assign obs[2] = {i_hs, i_vs, i_act, 32'($signed(i_x)), 32'($signed(i_y)),
                   32'(i_xc), 32'(i_yc), i_ls, i_fs};

  // Expected outputs for enabled-cycle count n since reset (mod frame).
  function automatic out_t exp_out(geom_t gg, int nn, int hs, int vs, bit a);
    int   col, line, m, x, y;
    out_t o;
    col  = nn % gg.ht;
    line = nn / gg.ht;
    m    = 1 << gg.pw;
    x    = col - gg.has - hs;
    y    = line - gg.vas - vs;
    x    = ((x % m) + m) % m;
    if (x >= m / 2) x -= m;
    y    = ((y % m) + m) % m;
    if (y >= m / 2) y -= m;
    o.act = (x >= 0) && (x < gg.ha) && (y >= 0) && (y < gg.va);
    o.x   = x;
    o.y   = y;
    o.xc  = o.act ? x / (1 << gg.sc) : 0;
    o.yc  = o.act ? y / (1 << gg.sc) : 0;
    o.hs  = (col >= gg.hss && col < gg.hss + gg.hsl) ? gg.hp : !gg.hp;
    o.vs  = (line < gg.vsl) ? gg.vp : !gg.vp;
    o.ls  = a && (col == 0);
    o.fs  = a && (col == 0) && (line == 0);
    return o;
  endfunction

  // One clock: advance the model from the inputs seen before the edge.
  task automatic tick();
    bit e [N];
    int hi [N];
    int vi [N];
    for (int i = 0; i < N; i++) begin
      e[i] = en[i]; hi[i] = int'(hsh[i]); vi[i] = int'(vsh[i]);
    end
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (rst[i]) begin
        n[i] = 0; hl[i] = 0; vl[i] = 0; adv[i] = 0;
      end else begin
        adv[i] = e[i];
        if (e[i]) begin
          n[i] = (n[i] + 1) % (g[i].ht * g[i].vt);
          if (n[i] == 0) begin
            hl[i] = hi[i]; vl[i] = vi[i];
          end
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    out_t e;
    repeat (3) tick();
    for (int i = 0; i < N; i++) begin
      e = exp_out(g[i], 0, 0, 0, 0);
      checks++;
      if (obs[i] !== e) $display("FAIL reset_held inst%0d got %h exp %h", i, obs[i], e);
      else passes++;
    end
    for (int i = 0; i < N; i++) rst[i] = 1'b0;
    tick();
    for (int i = 0; i < N; i++) begin
      e = exp_out(g[i], 0, 0, 0, 0);
      checks++;
      if (obs[i] !== e) $display("FAIL reset_release inst%0d got %h exp %h", i, obs[i], e);
      else passes++;
    end
  endtask

  task automatic test_default_active();
    out_t e;
    int   first = -1;
    en[0] = 1'b1;
    for (int k = 0; k < 27 * 310; k++) begin
      tick();
      e = exp_out(g[0], n[0], hl[0], vl[0], adv[0]);
      checks++;
      if (obs[0] !== e) $display("FAIL default_cycle n=%0d got %h exp %h", n[0], obs[0], e);
      else passes++;
      if (obs[0].act && first < 0) first = n[0];
    end
    en[0] = 1'b0;
    checks++;
    if (first != 26 * 310 + 9) $display("FAIL default_first_active got %0d exp %0d", first, 26 * 310 + 9);
    else passes++;
  endtask

  task automatic test_frame_period();
    out_t e;
    int   last_f = -1, last_l = -1, nf = 0;
    en[1] = 1'b1;
    for (int k = 1; k <= 3000; k++) begin
      tick();
      e = exp_out(g[1], n[1], hl[1], vl[1], adv[1]);
      checks++;
      if (obs[1] !== e) $display("FAIL period_cycle n=%0d got %h exp %h", n[1], obs[1], e);
      else passes++;
      if (obs[1].ls) begin
        if (last_l >= 0) begin
          checks++;
          if (k - last_l != S_HT) $display("FAIL line_period got %0d exp %0d", k - last_l, S_HT);
          else passes++;
        end
        last_l = k;
      end
      if (obs[1].fs) begin
        nf++;
        if (last_f >= 0) begin
          checks++;
          if (k - last_f != S_HT * S_VT) $display("FAIL frame_period got %0d exp %0d", k - last_f, S_HT * S_VT);
          else passes++;
        end
        last_f = k;
      end
    end
    checks++;
    if (nf != 2) $display("FAIL frame_count got %0d exp %0d", nf, 2);
    else passes++;
  endtask

  task automatic test_shift_latch();
    out_t e;
    bit   prev, found = 0;
    int   phase = 0, seen0 = 0;
    en[1] = 1'b1;
    for (int k = 0; k < 1300 && n[1] != 10 * S_HT + 7; k++) tick();
    hsh[1] = 4'd5;
    vsh[1] = 4'($urandom_range(0, 15));
    prev = obs[1].act;
    for (int k = 0; k < 2600 && !found; k++) begin
      tick();
      e = exp_out(g[1], n[1], hl[1], vl[1], adv[1]);
      checks++;
      if (obs[1] !== e) $display("FAIL shift_cycle n=%0d got %h exp %h", n[1], obs[1], e);
      else passes++;
      if (obs[1].fs) phase = 1;
      if (obs[1].act && !prev) begin
        checks++;
        if (phase == 0) begin
          seen0++;
          if (n[1] % S_HT != S_HAS) $display("FAIL shift_same_frame col got %0d exp %0d", n[1] % S_HT, S_HAS);
          else passes++;
        end else begin
          found = 1;
          if (n[1] % S_HT != S_HAS + 5) $display("FAIL shift_next_frame col got %0d exp %0d", n[1] % S_HT, S_HAS + 5);
          else passes++;
        end
      end
      prev = obs[1].act;
    end
    checks++;
    if (!found || seen0 == 0) $display("FAIL shift_edges found=%0d same_frame=%0d exp 1 and >0", found, seen0);
    else passes++;
  endtask

  task automatic test_enable_gaps();
    out_t e, snap;
    int   cnt = 0;
    bit   got = 0, paused = 0;
    for (int k = 0; k < 4000; k++) begin
      en[1] = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) begin
        hsh[1] = 4'($urandom_range(0, 15));
        vsh[1] = 4'($urandom_range(0, 15));
      end
      tick();
      e = exp_out(g[1], n[1], hl[1], vl[1], adv[1]);
      checks++;
      if (obs[1] !== e) $display("FAIL gaps_cycle n=%0d got %h exp %h", n[1], obs[1], e);
      else passes++;
    end
    en[1] = 1'b1;
    for (int k = 0; k < 1300 && !got; k++) begin
      tick();
      got = obs[1].fs;
    end
    checks++;
    if (!got) $display("FAIL hold_sync got no frameStart exp one within 1300");
    else passes++;
    got = 0;
    for (int k = 0; k < 2500 && !got; k++) begin
      if (!paused && n[1] == 5 * S_HT + 20) begin
        en[1] = 1'b0;
        snap = obs[1];
        repeat (7) begin
          tick();
          cnt++;
          checks++;
          if (obs[1] !== snap || obs[1].ls || obs[1].fs)
            $display("FAIL hold_frozen got %h exp %h", obs[1], snap);
          else passes++;
        end
        en[1] = 1'b1;
        paused = 1;
      end
      tick();
      cnt++;
      e = exp_out(g[1], n[1], hl[1], vl[1], adv[1]);
      checks++;
      if (obs[1] !== e) $display("FAIL hold_cycle n=%0d got %h exp %h", n[1], obs[1], e);
      else passes++;
      got = obs[1].fs;
    end
    checks++;
    if (!got || cnt != S_HT * S_VT + 7) $display("FAIL hold_period got %0d exp %0d", cnt, S_HT * S_VT + 7);
    else passes++;
  endtask

  task automatic test_async_reset();
    out_t e;
    int   cnt = 0;
    bit   got = 0;
    en[1] = 1'b1;
    hsh[1] = 4'($urandom_range(1, 15));
    vsh[1] = 4'($urandom_range(1, 15));
    for (int k = 0; k < 1300 && n[1] != 12 * S_HT + 15; k++) tick();
    #3 rst[1] = 1'b1;
    #1;
    n[1] = 0; hl[1] = 0; vl[1] = 0; adv[1] = 0;
    e = exp_out(g[1], 0, 0, 0, 0);
    checks++;
    if (obs[1] !== e) $display("FAIL async_reset_immediate got %h exp %h", obs[1], e);
    else passes++;
    repeat (2) tick();
    checks++;
    if (obs[1] !== e) $display("FAIL async_reset_held got %h exp %h", obs[1], e);
    else passes++;
    rst[1] = 1'b0;
    for (int k = 0; k < 1300 && !got; k++) begin
      tick();
      cnt++;
      e = exp_out(g[1], n[1], hl[1], vl[1], adv[1]);
      checks++;
      if (obs[1] !== e) $display("FAIL after_reset_cycle n=%0d got %h exp %h", n[1], obs[1], e);
      else passes++;
      got = obs[1].fs;
    end
    checks++;
    if (!got || cnt != S_HT * S_VT) $display("FAIL reset_to_frame got %0d exp %0d", cnt, S_HT * S_VT);
    else passes++;
  endtask

  task automatic test_inverted();
    out_t e;
    int   last_f = -1;
    en[2] = 1'b1;
    for (int k = 1; k <= 2 * I_HT * I_VT + 10; k++) begin
      tick();
      e = exp_out(g[2], n[2], hl[2], vl[2], adv[2]);
      checks++;
      if (obs[2] !== e) $display("FAIL inv_cycle n=%0d got %h exp %h", n[2], obs[2], e);
      else passes++;
      if (obs[2].fs) begin
        if (last_f >= 0) begin
          checks++;
          if (k - last_f != I_HT * I_VT) $display("FAIL inv_frame_period got %0d exp %0d", k - last_f, I_HT * I_VT);
          else passes++;
        end
        last_f = k;
      end
    end
    for (int k = 0; k < 800; k++) begin
      en[2] = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 19) == 0) begin
        hsh[2] = 4'($urandom_range(0, 15));
        vsh[2] = 4'($urandom_range(0, 15));
      end
      tick();
      e = exp_out(g[2], n[2], hl[2], vl[2], adv[2]);
      checks++;
      if (obs[2] !== e) $display("FAIL inv_rand_cycle n=%0d got %h exp %h", n[2], obs[2], e);
      else passes++;
      if (obs[2].act) begin
        checks++;
        if (obs[2].x < 0 || obs[2].x >= I_HA || obs[2].y < 0 || obs[2].y >= I_VA)
          $display("FAIL inv_rect x=%0d y=%0d exp inside %0dx%0d", obs[2].x, obs[2].y, I_HA, I_VA);
        else passes++;
      end
    end
  endtask

  initial begin
    g[0] = '{310, 263, 287, 23, 3, 9, 26, 256, 192, 2, 10, 1'b1, 1'b1};
    g[1] = '{S_HT, S_VT, S_HSS, S_HSL, S_VSL, S_HAS, S_VAS, S_HA, S_VA, S_SC, S_PW, 1'b1, 1'b1};
    g[2] = '{I_HT, I_VT, I_HSS, I_HSL, I_VSL, I_HAS, I_VAS, I_HA, I_VA, I_SC, I_PW, 1'b0, 1'b0};
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b1; en[i] = 1'b0; hsh[i] = '0; vsh[i] = '0;
      n[i] = 0; hl[i] = 0; vl[i] = 0; adv[i] = 0;
    end
    #2;
    test_reset();
    test_default_active();
    test_frame_period();
    test_shift_latch();
    test_enable_gaps();
    test_async_reset();
    test_inverted();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
